instruction_prefetch_queue: RTL and testbench

Sequential instruction fetch stage that sits directly upstream of the decode/execute dataflow core. It owns the fetch program counter, issues word reads on the core's instruction memory port, and buffers returned opcodes in a small FIFO. It presents each opcode with its address to decode over a valid/ready handshake. Branches and jumps redirect it through a flush port that empties the queue and discards any in-flight read.

---
 rtl/instruction_prefetch_queue.sv | 138 +++++++++++++
 tb/tb_instruction_prefetch_queue.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch_queue.sv
// Sequential instruction fetch stage: owns the fetch PC, issues word reads and buffers opcodes in a DEPTH-entry FIFO.
// Define PREFETCH_PERF_EN to add the saturating o_perf_fetched / o_perf_discarded counters.
module instruction_prefetch_queue #(
  parameter int                   BUS_WIDTH = 32,
  parameter int                   DEPTH     = 4,
  parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  output logic [BUS_WIDTH-1:0] o_mem_addr,
  output logic                 o_mem_request,
  input  logic                 i_mem_busy,
  input  logic [BUS_WIDTH-1:0] i_mem_data,
  output logic                 o_op_valid,
  input  logic                 i_op_ready,
  output logic [BUS_WIDTH-1:0] o_op_data,
  output logic [BUS_WIDTH-1:0] o_op_pc,
  input  logic                 i_redirect,
  input  logic [BUS_WIDTH-1:0] i_redirect_pc
`ifdef PREFETCH_PERF_EN
  ,
  output logic [15:0]          o_perf_fetched,
  output logic [15:0]          o_perf_discarded
`endif
);

  localparam int            PW         = $clog2(DEPTH);
  localparam int            CW         = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [BUS_WIDTH-1:0] r_fetch_pc;
  logic [BUS_WIDTH-1:0] r_mem_addr;
  logic [BUS_WIDTH-1:0] r_data [DEPTH];
  logic [BUS_WIDTH-1:0] r_pc   [DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 w_complete;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_discard;
  logic                 w_start;
  logic [BUS_WIDTH-1:0] w_redirect_pc;

  assign w_redirect_pc = i_redirect_pc & ~BUS_WIDTH'(3);
  assign w_complete    = o_mem_request && !i_mem_busy;
  assign w_push        = (r_state == REQ) && w_complete && !i_redirect;
  assign w_discard     = w_complete && ((r_state == DRAIN) || i_redirect);
  assign w_pop         = o_op_valid && i_op_ready && !i_redirect;
  // A read is only launched when a slot is guaranteed free, so a push can never overflow.
  assign w_start       = (r_state == IDLE) && !i_redirect && (r_count < FULL_COUNT);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:  if (w_start) w_next_state = REQ;
      REQ: begin
        if (w_complete)      w_next_state = IDLE;
        else if (i_redirect) w_next_state = DRAIN;
      end
      DRAIN: if (w_complete) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_mem_request = (r_state != IDLE);
    o_mem_addr    = r_mem_addr;
    o_op_valid    = (r_count != '0);
    o_op_data     = r_data[r_rd_ptr];
    o_op_pc       = r_pc[r_rd_ptr];
  end

  // The issued address is latched separately so a redirect cannot disturb a read that is still in flight.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fetch_pc <= RESET_PC;
      r_mem_addr <= RESET_PC;
    end else begin
      if (i_redirect)  r_fetch_pc <= w_redirect_pc;
      else if (w_push) r_fetch_pc <= r_fetch_pc + BUS_WIDTH'(4);
      if (w_start)     r_mem_addr <= r_fetch_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (i_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= i_mem_data;
        r_pc[r_wr_ptr]   <= r_mem_addr;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

`ifdef PREFETCH_PERF_EN
  logic [15:0] r_perf_fetched;
  logic [15:0] r_perf_discarded;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_perf_fetched   <= '0;
      r_perf_discarded <= '0;
    end else begin
      if (w_push && (r_perf_fetched != 16'hFFFF))      r_perf_fetched   <= r_perf_fetched + 16'd1;
      if (w_discard && (r_perf_discarded != 16'hFFFF)) r_perf_discarded <= r_perf_discarded + 16'd1;
    end
  end

  assign o_perf_fetched   = r_perf_fetched;
  assign o_perf_discarded = r_perf_discarded;
`endif

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Self-checking bench for instruction_prefetch_queue: zero/variable-wait memory model returning addr^0xA5A5_0000,
// a scoreboard of expected opcodes, a table of redirect/wrap vectors and hand-written corner-case sequences.
module tb_instruction_prefetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  typedef struct {
    logic [31:0] redirPc;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [31:0] exp3;
  } vec_t;

  logic        clock = 1'b0;
  logic        resetN;
  logic [31:0] memAddr;
  logic        memRequest;
  logic        memBusy;
  logic [31:0] memData;
  logic        opValid;
  logic        opReady;
  logic [31:0] opData;
  logic [31:0] opPc;
  logic        redirect;
  logic [31:0] redirectPc;
`ifdef PREFETCH_PERF_EN
  logic [15:0] perfFetched;
  logic [15:0] perfDiscarded;
`endif

  int          cmpCount = 0;
  int          errCount = 0;
  int          popCount = 0;
  entry_t      sbQueue [$];
  logic [31:0] expFetch = RESET_PC;
  bit          prevReq = 1'b0;

  assign memData = memAddr ^ KEY;

  always #5 clock = ~clock;

  instruction_prefetch_queue #(
    .BUS_WIDTH (32),
    .DEPTH     (4),
    .RESET_PC  (RESET_PC)
  ) dut (
    .i_clk            (clock),
    .i_reset          (resetN),
    .o_mem_addr       (memAddr),
    .o_mem_request    (memRequest),
    .i_mem_busy       (memBusy),
    .i_mem_data       (memData),
    .o_op_valid       (opValid),
    .i_op_ready       (opReady),
    .o_op_data        (opData),
    .o_op_pc          (opPc),
    .i_redirect       (redirect),
    .i_redirect_pc    (redirectPc)
`ifdef PREFETCH_PERF_EN
    ,
    .o_perf_fetched   (perfFetched),
    .o_perf_discarded (perfDiscarded)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    cmpCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic failTimeout(input string name);
    cmpCount++;
    errCount++;
    $display("[TB] FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] pc, input logic ready);
    redirect   = redir;
    redirectPc = pc;
    opReady    = ready;
  endtask

  task automatic redirectTo(input logic [31:0] pc);
    applyStimulus(1'b1, pc, opReady);
    prevReq = memRequest;
    tick();
    applyStimulus(1'b0, pc, opReady);
  endtask

  // A "new" request is a rising edge of mem_request; a drain continuing across a redirect is not one.
  task automatic waitNewRequest(output logic [31:0] addr, output bit ok);
    ok   = 1'b0;
    addr = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (memRequest && !prevReq) begin
        ok   = 1'b1;
        addr = memAddr;
      end else begin
        prevReq = memRequest;
        tick();
      end
    end
    prevReq = memRequest;
    if (!ok) failTimeout("new-request");
  endtask

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (opValid) ok = 1'b1;
      else tick();
    end
    if (!ok) failTimeout("op-valid");
  endtask

  function automatic vec_t mkVec(input logic [31:0] pc, input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2, input logic [31:0] a3);
    vec_t v;
    v.redirPc = pc;
    v.exp0    = a0;
    v.exp1    = a1;
    v.exp2    = a2;
    v.exp3    = a3;
    return v;
  endfunction

  // Scoreboard: expected opcodes are queued when the memory answers the expected fetch address, checked on pops.
  always @(negedge clock) begin
    entry_t expEntry;
    if (!resetN) begin
      sbQueue.delete();
      expFetch = RESET_PC;
    end else begin
      if (opValid && opReady && !redirect) begin
        popCount++;
        if (sbQueue.size() == 0) begin
          cmpCount++;
          errCount++;
          $display("[TB] FAIL pop-unexpected: got op_pc %h, expected no opcode (t=%0t)", opPc, $time);
        end else begin
          expEntry = sbQueue.pop_front();
          checkOutput("pop-pc", opPc, expEntry.pc);
          checkOutput("pop-data", opData, expEntry.data);
        end
      end
      if (memRequest && !memBusy && !redirect && (memAddr == expFetch)) begin
        sbQueue.push_back('{expFetch, expFetch ^ KEY});
        expFetch = expFetch + 32'd4;
      end
      if (redirect) begin
        sbQueue.delete();
        expFetch = redirectPc & ~32'h3;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [4];
    logic [31:0] reqLog [$];
    logic [31:0] a;
    logic [31:0] got [4];
    bit          ok;
    int          p0;
`ifdef PREFETCH_PERF_EN
    logic [15:0] discBefore;
`endif

    vecs[0] = mkVec(32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004);
    vecs[1] = mkVec(32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008);
    vecs[2] = mkVec(32'h0000_0123, 32'h0000_0120, 32'h0000_0124, 32'h0000_0128, 32'h0000_012C);
    vecs[3] = mkVec(32'h0000_1005, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C, 32'h0000_1010);

    resetN  = 1'b0;
    memBusy = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Reset state and sequential fill with decode stalled.
    #3;
    checkOutput("reset-request", 32'(memRequest), 32'd0);
    checkOutput("reset-addr", memAddr, RESET_PC);
    checkOutput("reset-valid", 32'(opValid), 32'd0);
    checkOutput("reset-data", opData, 32'd0);
    checkOutput("reset-pc", opPc, 32'd0);
    #9;
    resetN = 1'b1;
    tick();
    checkOutput("first-request", 32'(memRequest), 32'd1);
    checkOutput("first-addr", memAddr, RESET_PC);
    for (int i = 0; i < 20; i++) begin
      if (memRequest) reqLog.push_back(memAddr);
      tick();
    end
    checkOutput("fill-count", 32'(reqLog.size()), 32'd4);
    for (int i = 0; i < reqLog.size() && i < 4; i++) checkOutput("fill-addr", reqLog[i], 32'(4 * i));
    checkOutput("full-request", 32'(memRequest), 32'd0);
    checkOutput("full-valid", 32'(opValid), 32'd1);
    checkOutput("full-head-pc", opPc, 32'h0);
    checkOutput("full-head-data", opData, KEY);

    // Streaming: one pop every two cycles in steady state, in order, 64 words.
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    p0 = popCount;
    for (int i = 0; i < 64; i++) tick();
    checkOutput("stream-rate", 32'(popCount - p0), 32'd32);
    for (int i = 0; i < 200 && popCount < 64; i++) tick();
    checkOutput("stream-total", 32'(popCount), 32'd64);

    // Redirect to 0x103 while a read of 0x10 is held busy for three cycles.
    applyStimulus(1'b0, 32'h0, 1'b0);
    redirectTo(32'h10);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (memRequest && memAddr == 32'h10) ok = 1'b1;
      else tick();
    end
    if (!ok) failTimeout("busy-setup");
    memBusy = 1'b1;
`ifdef PREFETCH_PERF_EN
    discBefore = perfDiscarded;
`endif
    tick();
    tick();
    applyStimulus(1'b1, 32'h103, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    memBusy = 1'b0;
    checkOutput("drain-hold-addr", memAddr, 32'h10);
    prevReq = memRequest;
    waitNewRequest(a, ok);
    if (ok) checkOutput("busy-next-addr", a, 32'h100);
    applyStimulus(1'b0, 32'h0, 1'b1);
    waitValid(ok);
    if (ok) checkOutput("busy-first-pc", opPc, 32'h100);
`ifdef PREFETCH_PERF_EN
    checkOutput("perf-discarded", 32'(perfDiscarded - discBefore), 32'd1);
`endif

    // Redirect coinciding with a pop and a read completion.
    applyStimulus(1'b0, 32'h0, 1'b0);
    redirectTo(32'h200);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (memRequest && opValid) ok = 1'b1;
      else tick();
    end
    if (!ok) failTimeout("simul-setup");
    applyStimulus(1'b1, 32'h40, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("simul-valid", 32'(opValid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    waitValid(ok);
    if (ok) checkOutput("simul-first-pc", opPc, 32'h40);

    // Table of redirect targets: alignment and wrap-around of the fetch address.
    for (int v = 0; v < 4; v++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      redirectTo(vecs[v].redirPc);
      for (int k = 0; k < 4; k++) begin
        waitNewRequest(a, ok);
        got[k] = ok ? a : 32'hDEAD_BEEF;
      end
      checkOutput("vec-addr0", got[0], vecs[v].exp0);
      checkOutput("vec-addr1", got[1], vecs[v].exp1);
      checkOutput("vec-addr2", got[2], vecs[v].exp2);
      checkOutput("vec-addr3", got[3], vecs[v].exp3);
    end

    // Back-to-back redirects: only the last target is fetched.
    applyStimulus(1'b1, 32'h500, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h600, 1'b1);
    prevReq = memRequest;
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    waitNewRequest(a, ok);
    if (ok) checkOutput("b2b-addr", a, 32'h600);
    waitValid(ok);
    if (ok) checkOutput("b2b-first-pc", opPc, 32'h600);

    // Asynchronous reset in the middle of a busy read.
    applyStimulus(1'b0, 32'h0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (memRequest && opValid) ok = 1'b1;
      else tick();
    end
    if (!ok) failTimeout("areset-setup");
    memBusy = 1'b1;
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("areset-request", 32'(memRequest), 32'd0);
    checkOutput("areset-valid", 32'(opValid), 32'd0);
    checkOutput("areset-addr", memAddr, RESET_PC);
    @(posedge clock);
    #3;
    memBusy = 1'b0;
    resetN  = 1'b1;
    tick();
    checkOutput("restart-request", 32'(memRequest), 32'd1);
    checkOutput("restart-addr", memAddr, RESET_PC);
    applyStimulus(1'b0, 32'h0, 1'b1);
    waitValid(ok);
    if (ok) checkOutput("restart-first-pc", opPc, RESET_PC);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
